pc_fetch_gen: RTL and testbench

PC_FETCH_GEN -- requirements
Module: pc_fetch_gen

---
 rtl/pc_fetch_gen.sv | 123 ++++++++++++
 tb/tb_pc_fetch_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_gen.sv
// Fetch PC generator: issues sequential fetch requests, absorbs redirects that
// arrive while a request is outstanding into a one-entry buffer.
module pc_fetch_gen #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter int unsigned        INC       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_valid_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
  input  logic              req_ready_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              redirect_pending_o
);

  typedef enum logic [1:0] {BOOT = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic                buf_valid_reg, buf_valid_next;
  logic                buf_trap_reg, buf_trap_next;
  logic [ADDR_W-1:0]   buf_pc_reg, buf_pc_next;

  logic                fire;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   branch_aligned;
  logic [ADDR_W-1:0]   trap_aligned;
  logic                redir_valid;
  logic [ADDR_W-1:0]   redir_pc;

  assign fire           = req_valid_o & req_ready_i;
  assign pc_inc         = pc_reg + ADDR_W'(INC);
  assign branch_aligned = {branch_pc_i[ADDR_W-1:2], 2'b00};
  assign trap_aligned   = {trap_pc_i[ADDR_W-1:2], 2'b00};

  assign pc_o               = pc_reg;
  assign next_pc_o          = pc_inc;
  assign redirect_pending_o = buf_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= BOOT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:    state_next = stall_i ? HOLD : REQ;
      REQ:     if (fire) state_next = stall_i ? HOLD : REQ;
      HOLD:    state_next = stall_i ? HOLD : REQ;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    req_valid_o = (state_reg == REQ);
  end

  // Incoming trap beats a buffered trap, which beats any branch.
  always_comb begin
    redir_valid = 1'b0;
    redir_pc    = '0;
    if (trap_valid_i) begin
      redir_valid = 1'b1;
      redir_pc    = trap_aligned;
    end else if (buf_valid_reg && buf_trap_reg) begin
      redir_valid = 1'b1;
      redir_pc    = buf_pc_reg;
    end else if (branch_valid_i) begin
      redir_valid = 1'b1;
      redir_pc    = branch_aligned;
    end else if (buf_valid_reg) begin
      redir_valid = 1'b1;
      redir_pc    = buf_pc_reg;
    end
  end

  always_comb begin
    pc_next        = pc_reg;
    buf_valid_next = buf_valid_reg;
    buf_trap_next  = buf_trap_reg;
    buf_pc_next    = buf_pc_reg;
    if (state_reg == REQ) begin
      if (fire) begin
        pc_next        = redir_valid ? redir_pc : pc_inc;
        buf_valid_next = 1'b0;
      end else if (trap_valid_i) begin
        buf_valid_next = 1'b1;
        buf_trap_next  = 1'b1;
        buf_pc_next    = trap_aligned;
      end else if (branch_valid_i && !(buf_valid_reg && buf_trap_reg)) begin
        buf_valid_next = 1'b1;
        buf_trap_next  = 1'b0;
        buf_pc_next    = branch_aligned;
      end
    end else begin
      // No request in flight: redirects (including a stale entry) land directly.
      if (redir_valid) pc_next = redir_pc;
      buf_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg        <= RESET_VEC;
      buf_valid_reg <= 1'b0;
      buf_trap_reg  <= 1'b0;
      buf_pc_reg    <= '0;
    end else begin
      pc_reg        <= pc_next;
      buf_valid_reg <= buf_valid_next;
      buf_trap_reg  <= buf_trap_next;
      buf_pc_reg    <= buf_pc_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen: expected fetch addresses are queued as
// stimulus is applied and popped by a monitor each time a request fires.
module tb_pc_fetch_gen;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;
  localparam logic [31:0] Z = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_valid_i = 1'b0;
  logic [31:0] branch_pc_i = '0;
  logic        trap_valid_i = 1'b0;
  logic [31:0] trap_pc_i = '0;
  logic        req_ready_i = 1'b0;
  logic        req_valid_o;
  logic [31:0] pc_o;
  logic [31:0] next_pc_o;
  logic        redirect_pending_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  pc_fetch_gen #(.ADDR_W(32), .RESET_VEC(32'h0), .INC(4)) dut (
    .clk(clk),
    .rst(rst),
    .stall_i(stall_i),
    .branch_valid_i(branch_valid_i),
    .branch_pc_i(branch_pc_i),
    .trap_valid_i(trap_valid_i),
    .trap_pc_i(trap_pc_i),
    .req_ready_i(req_ready_i),
    .req_valid_o(req_valid_o),
    .pc_o(pc_o),
    .next_pc_o(next_pc_o),
    .redirect_pending_o(redirect_pending_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply inputs for one rising edge, return just after it.
  task automatic step(input logic rdy, input logic st,
                      input logic bv, input logic [31:0] bpc,
                      input logic tv, input logic [31:0] tpc);
    req_ready_i    = rdy;
    stall_i        = st;
    branch_valid_i = bv;
    branch_pc_i    = bpc;
    trap_valid_i   = tv;
    trap_pc_i      = tpc;
    @(posedge clk);
    #1;
  endtask

  // Inputs are stable mid-cycle, so this sees exactly the handshakes of the next edge.
  always @(negedge clk) begin
    if (!rst && req_valid_o && req_ready_i) begin
      if (exp_q.size() == 0) begin
        check("fire_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        $display("[TB] fetch pc=0x%08h expected=0x%08h", pc_o, e);
        check("fire_pc", pc_o, e);
      end
    end
  end

  initial begin
    rst = 1'b1;
    step(Y, N, N, Z, N, Z);
    step(Y, N, N, Z, N, Z);
    check("rst_valid", 32'(req_valid_o), 32'd0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_pend", 32'(redirect_pending_o), 32'd0);
    check("rst_next_pc", next_pc_o, 32'h4);

    // Sequential fetch after reset release.
    rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    step(Y, N, N, Z, N, Z);
    check("boot_valid", 32'(req_valid_o), 32'd1);
    check("boot_pc", pc_o, 32'h0);
    step(Y, N, N, Z, N, Z);
    check("seq_pc4", pc_o, 32'h4);
    step(Y, N, N, Z, N, Z);
    step(Y, N, N, Z, N, Z);
    check("seq_pcC", pc_o, 32'hC);
    check("seq_next_pc", next_pc_o, 32'h10);
    step(Y, N, N, Z, N, Z);
    check("seq_pc10", pc_o, 32'h10);

    // Backpressure with a branch buffered.
    step(N, N, Y, 32'h100, N, Z);
    check("bp_pc_hold", pc_o, 32'h10);
    check("bp_pend", 32'(redirect_pending_o), 32'd1);
    step(N, Y, N, Z, N, Z);
    step(N, N, N, Z, N, Z);
    check("bp_pc_hold3", pc_o, 32'h10);
    check("bp_valid_hold", 32'(req_valid_o), 32'd1);
    exp_q.push_back(32'h10);
    step(Y, N, N, Z, N, Z);
    check("bp_pc_redir", pc_o, 32'h100);
    check("bp_pend_clr", 32'(redirect_pending_o), 32'd0);

    // Buffered trap survives a later branch.
    exp_q.push_back(32'h100);
    step(Y, N, N, Z, Y, 32'h20);
    check("trap_fire_pc", pc_o, 32'h20);
    step(N, N, Y, 32'h200, N, Z);
    step(N, N, N, Z, Y, 32'h80);
    step(N, N, Y, 32'h300, N, Z);
    check("prio_pc_hold", pc_o, 32'h20);
    check("prio_pend", 32'(redirect_pending_o), 32'd1);
    exp_q.push_back(32'h20);
    step(Y, N, N, Z, N, Z);
    check("prio_pc", pc_o, 32'h80);

    // Simultaneous trap and branch; unaligned branch target.
    exp_q.push_back(32'h80);
    step(Y, N, Y, 32'h400, Y, 32'h80);
    check("simul_pc", pc_o, 32'h80);
    exp_q.push_back(32'h80);
    step(Y, N, Y, 32'h103, N, Z);
    check("align_pc", pc_o, 32'h100);
    step(N, N, N, Z, Y, 32'h40);
    exp_q.push_back(32'h100);
    step(Y, N, Y, 32'h600, N, Z);
    check("buftrap_vs_branch", pc_o, 32'h40);
    check("buftrap_pend_clr", 32'(redirect_pending_o), 32'd0);

    // Stall into HOLD, redirect while holding.
    exp_q.push_back(32'h40);
    step(Y, Y, N, Z, N, Z);
    check("hold_valid", 32'(req_valid_o), 32'd0);
    check("hold_pc", pc_o, 32'h44);
    step(Y, Y, Y, 32'h500, N, Z);
    check("hold_redir_pc", pc_o, 32'h500);
    check("hold_pend", 32'(redirect_pending_o), 32'd0);
    step(Y, Y, N, Z, N, Z);
    check("hold_stay_valid", 32'(req_valid_o), 32'd0);
    step(Y, N, N, Z, N, Z);
    check("unstall_valid", 32'(req_valid_o), 32'd1);
    check("unstall_pc", pc_o, 32'h500);

    // Wrap-around.
    exp_q.push_back(32'h500);
    step(Y, N, N, Z, Y, 32'hFFFF_FFFF);
    check("top_pc", pc_o, 32'hFFFF_FFFC);
    check("top_next_pc", next_pc_o, 32'h0);
    exp_q.push_back(32'hFFFF_FFFC);
    step(Y, N, N, Z, N, Z);
    check("wrap_pc", pc_o, 32'h0);
    exp_q.push_back(32'h0);
    step(Y, N, N, Z, N, Z);

    // Reset mid-handshake drops the request and the buffer.
    step(N, N, Y, 32'h700, N, Z);
    check("pre_rst_pend", 32'(redirect_pending_o), 32'd1);
    rst = 1'b1;
    step(N, N, N, Z, N, Z);
    check("mid_rst_pc", pc_o, 32'h0);
    check("mid_rst_valid", 32'(req_valid_o), 32'd0);
    check("mid_rst_pend", 32'(redirect_pending_o), 32'd0);
    rst = 1'b0;
    step(Y, N, N, Z, N, Z);
    check("rerun_pc", pc_o, 32'h0);
    exp_q.push_back(32'h0);
    step(Y, N, N, Z, N, Z);
    check("rerun_pc4", pc_o, 32'h4);

    // BOOT with stall goes to HOLD.
    rst = 1'b1;
    step(N, N, N, Z, N, Z);
    rst = 1'b0;
    step(Y, Y, N, Z, N, Z);
    check("boot_stall_valid", 32'(req_valid_o), 32'd0);
    step(N, N, N, Z, N, Z);
    check("boot_stall_req", 32'(req_valid_o), 32'd1);
    step(N, N, N, Z, N, Z);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
